// File: rtl/recirc_merger_if.sv
// rtl/recirc_merger_if.sv - lane bundle for the four-lane recirculation merger
// Purpose: groups the per-lane fresh, recirculated and merged signals.
// Signals (lane i = 0..3):
//   dataIn<i>, validIn<i>           fresh upstream word and its valid
//   recircIn<i>, recircValid<i>     recirculated word and its valid
//   dataOut<i>, validOut<i>         registered merged word and its valid
//   full<i>                         lane FIFO holds FIFO_DEPTH entries
//   overflow<i>                     sticky: a fresh word was dropped on the lane
// Modports: master drives fresh/recirculated inputs, slave is the merger.
interface recirc_merger_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dataIn0, dataIn1, dataIn2, dataIn3;
    logic              validIn0, validIn1, validIn2, validIn3;
    logic [DATA_W-1:0] recircIn0, recircIn1, recircIn2, recircIn3;
    logic              recircValid0, recircValid1, recircValid2, recircValid3;
    logic [DATA_W-1:0] dataOut0, dataOut1, dataOut2, dataOut3;
    logic              validOut0, validOut1, validOut2, validOut3;
    logic              full0, full1, full2, full3;
    logic              overflow0, overflow1, overflow2, overflow3;

    modport master (
        output dataIn0, dataIn1, dataIn2, dataIn3,
        output validIn0, validIn1, validIn2, validIn3,
        output recircIn0, recircIn1, recircIn2, recircIn3,
        output recircValid0, recircValid1, recircValid2, recircValid3,
        input  dataOut0, dataOut1, dataOut2, dataOut3,
        input  validOut0, validOut1, validOut2, validOut3,
        input  full0, full1, full2, full3,
        input  overflow0, overflow1, overflow2, overflow3
    );

    modport slave (
        input  dataIn0, dataIn1, dataIn2, dataIn3,
        input  validIn0, validIn1, validIn2, validIn3,
        input  recircIn0, recircIn1, recircIn2, recircIn3,
        input  recircValid0, recircValid1, recircValid2, recircValid3,
        output dataOut0, dataOut1, dataOut2, dataOut3,
        output validOut0, validOut1, validOut2, validOut3,
        output full0, full1, full2, full3,
        output overflow0, overflow1, overflow2, overflow3
    );
endinterface

// File: rtl/recirc_merger.sv
// rtl/recirc_merger.sv - four-lane merge of recirculated and fresh data
// Purpose: per lane, recirculated data wins; fresh data that loses is queued
//   in a per-lane FIFO and drained, in order, whenever the lane is free.
// Ports:
//   clk    single clock, all state on posedge
//   reset  asynchronous, active-high; clears outputs, counts and pointers
//   bus    recirc_merger_if.slave carrying all four lanes
module recirc_merger #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic          clk,
    input  logic          reset,
    recirc_merger_if.slave bus
);
    localparam int NLANES = 4;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] laneDataIn   [NLANES];
    logic              laneValidIn  [NLANES];
    logic [DATA_W-1:0] laneRecircIn [NLANES];
    logic              laneRecircV  [NLANES];
    logic [DATA_W-1:0] laneDataOut  [NLANES];
    logic              laneValidOut [NLANES];
    logic              laneFull     [NLANES];
    logic              laneOverflow [NLANES];

    assign laneDataIn[0] = bus.dataIn0;
    assign laneDataIn[1] = bus.dataIn1;
    assign laneDataIn[2] = bus.dataIn2;
    assign laneDataIn[3] = bus.dataIn3;
    assign laneValidIn[0] = bus.validIn0;
    assign laneValidIn[1] = bus.validIn1;
    assign laneValidIn[2] = bus.validIn2;
    assign laneValidIn[3] = bus.validIn3;
    assign laneRecircIn[0] = bus.recircIn0;
    assign laneRecircIn[1] = bus.recircIn1;
    assign laneRecircIn[2] = bus.recircIn2;
    assign laneRecircIn[3] = bus.recircIn3;
    assign laneRecircV[0] = bus.recircValid0;
    assign laneRecircV[1] = bus.recircValid1;
    assign laneRecircV[2] = bus.recircValid2;
    assign laneRecircV[3] = bus.recircValid3;

    assign bus.dataOut0 = laneDataOut[0];
    assign bus.dataOut1 = laneDataOut[1];
    assign bus.dataOut2 = laneDataOut[2];
    assign bus.dataOut3 = laneDataOut[3];
    assign bus.validOut0 = laneValidOut[0];
    assign bus.validOut1 = laneValidOut[1];
    assign bus.validOut2 = laneValidOut[2];
    assign bus.validOut3 = laneValidOut[3];
    assign bus.full0 = laneFull[0];
    assign bus.full1 = laneFull[1];
    assign bus.full2 = laneFull[2];
    assign bus.full3 = laneFull[3];
    assign bus.overflow0 = laneOverflow[0];
    assign bus.overflow1 = laneOverflow[1];
    assign bus.overflow2 = laneOverflow[2];
    assign bus.overflow3 = laneOverflow[3];

    for (genvar g = 0; g < NLANES; g++) begin : gLane
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  rdPtr, wrPtr;
        logic [PTR_W:0]    count;
        logic [DATA_W-1:0] dataOutR;
        logic              validOutR, overflowR;
        logic              isFull, notEmpty, doPush, doPop, doDrop;

        always_comb begin
            isFull   = (count == DEPTH_CNT);
            notEmpty = (count != '0);
            // The FIFO head drains only when recirculation leaves the lane free.
            doPop    = !laneRecircV[g] && notEmpty;
            // With recirculation active a push needs a free slot; while draining
            // the pop frees one on the same edge, so a push is always legal.
            // With an empty FIFO and no recirculation the word bypasses instead.
            doPush   = laneValidIn[g] && (laneRecircV[g] ? !isFull : notEmpty);
            doDrop   = laneValidIn[g] && laneRecircV[g] && isFull;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdPtr     <= '0;
                wrPtr     <= '0;
                count     <= '0;
                dataOutR  <= '0;
                validOutR <= 1'b0;
                overflowR <= 1'b0;
            end else begin
                if (doPush) wrPtr <= wrPtr + 1'b1;
                if (doPop)  rdPtr <= rdPtr + 1'b1;
                if (doPush && !doPop)      count <= count + 1'b1;
                else if (doPop && !doPush) count <= count - 1'b1;
                if (doDrop) overflowR <= 1'b1;

                if (laneRecircV[g]) begin
                    dataOutR  <= laneRecircIn[g];
                    validOutR <= 1'b1;
                end else if (notEmpty) begin
                    dataOutR  <= mem[rdPtr];
                    validOutR <= 1'b1;
                end else if (laneValidIn[g]) begin
                    dataOutR  <= laneDataIn[g];
                    validOutR <= 1'b1;
                end else begin
                    validOutR <= 1'b0;
                end
            end
        end

        // Storage needs no reset: entries are only read once count covers them.
        always_ff @(posedge clk) begin
            if (doPush) mem[wrPtr] <= laneDataIn[g];
        end

        assign laneDataOut[g]  = dataOutR;
        assign laneValidOut[g] = validOutR;
        assign laneFull[g]     = isFull;
        assign laneOverflow[g] = overflowR;
    end
endmodule

// File: tb/tb_recirc_merger.sv
// tb/tb_recirc_merger.sv - self-checking bench for recirc_merger
module tb_recirc_merger;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    recirc_merger_if #(.DATA_W(8)) ifc ();

    recirc_merger #(.DATA_W(8), .FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (ifc)
    );

    logic [7:0] dIn [4];
    logic       vIn [4];
    logic [7:0] rIn [4];
    logic       rv  [4];

    assign ifc.dataIn0 = dIn[0];
    assign ifc.dataIn1 = dIn[1];
    assign ifc.dataIn2 = dIn[2];
    assign ifc.dataIn3 = dIn[3];
    assign ifc.validIn0 = vIn[0];
    assign ifc.validIn1 = vIn[1];
    assign ifc.validIn2 = vIn[2];
    assign ifc.validIn3 = vIn[3];
    assign ifc.recircIn0 = rIn[0];
    assign ifc.recircIn1 = rIn[1];
    assign ifc.recircIn2 = rIn[2];
    assign ifc.recircIn3 = rIn[3];
    assign ifc.recircValid0 = rv[0];
    assign ifc.recircValid1 = rv[1];
    assign ifc.recircValid2 = rv[2];
    assign ifc.recircValid3 = rv[3];

    logic [7:0] oData [4];
    logic       oValid [4];
    logic       oFull [4];
    logic       oOvf [4];

    assign oData[0] = ifc.dataOut0;
    assign oData[1] = ifc.dataOut1;
    assign oData[2] = ifc.dataOut2;
    assign oData[3] = ifc.dataOut3;
    assign oValid[0] = ifc.validOut0;
    assign oValid[1] = ifc.validOut1;
    assign oValid[2] = ifc.validOut2;
    assign oValid[3] = ifc.validOut3;
    assign oFull[0] = ifc.full0;
    assign oFull[1] = ifc.full1;
    assign oFull[2] = ifc.full2;
    assign oFull[3] = ifc.full3;
    assign oOvf[0] = ifc.overflow0;
    assign oOvf[1] = ifc.overflow1;
    assign oOvf[2] = ifc.overflow2;
    assign oOvf[3] = ifc.overflow3;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int lane, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d at %0t: got %h expected %h", name, lane, $time, act, exp);
        end
    endtask

    // Reference model: each lane keeps its waiting fresh words as an ordered list.
    logic [7:0] mq [4][8];
    int         mSize [4];
    logic [7:0] eOut [4];
    logic       eValid [4];
    logic       eOvf [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mSize[i] = 0; eOut[i] = 8'h00; eValid[i] = 1'b0; eOvf[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rv[i]) begin
                    eOut[i] = rIn[i]; eValid[i] = 1'b1;
                    if (vIn[i]) begin
                        if (mSize[i] < 4) begin mq[i][mSize[i]] = dIn[i]; mSize[i]++; end
                        else eOvf[i] = 1'b1;
                    end
                end else if (mSize[i] > 0) begin
                    eOut[i] = mq[i][0]; eValid[i] = 1'b1;
                    for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
                    mSize[i]--;
                    if (vIn[i]) begin mq[i][mSize[i]] = dIn[i]; mSize[i]++; end
                end else if (vIn[i]) begin
                    eOut[i] = dIn[i]; eValid[i] = 1'b1;
                end else begin
                    eValid[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk("dataOut", i, oData[i], eOut[i]);
            chk("validOut", i, {7'd0, oValid[i]}, {7'd0, eValid[i]});
            chk("full", i, {7'd0, oFull[i]}, {7'd0, (mSize[i] == 4)});
            chk("overflow", i, {7'd0, oOvf[i]}, {7'd0, eOvf[i]});
        end
    end

    task automatic idleAll();
        for (int i = 0; i < 4; i++) begin
            vIn[i] = 1'b0; rv[i] = 1'b0; dIn[i] = 'x; rIn[i] = 'x;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idleAll();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("lit_reset_valid", i, {7'd0, oValid[i]}, 8'h00);
            chk("lit_reset_data", i, oData[i], 8'h00);
        end

        // Bypass on lane0
        vIn[0] = 1'b1; dIn[0] = 8'hFF; tick();
        chk("lit_bypass1", 0, oData[0], 8'hFF);
        dIn[0] = 8'hBB; tick();
        chk("lit_bypass2", 0, oData[0], 8'hBB);
        chk("lit_bypass_full", 0, {7'd0, oFull[0]}, 8'h00);
        idleAll(); tick();
        chk("lit_idle_valid", 0, {7'd0, oValid[0]}, 8'h00);
        chk("lit_idle_hold", 0, oData[0], 8'hBB);

        // Priority and ordering on lane1
        rv[1] = 1'b1; rIn[1] = 8'hAA; vIn[1] = 1'b1; dIn[1] = 8'hEE; tick();
        chk("lit_prio_aa", 1, oData[1], 8'hAA);
        rv[1] = 1'b0; rIn[1] = 'x; dIn[1] = 8'h99; tick();
        chk("lit_prio_ee", 1, oData[1], 8'hEE);
        idleAll(); tick();
        chk("lit_prio_99", 1, oData[1], 8'h99);
        chk("lit_prio_v", 1, {7'd0, oValid[1]}, 8'h01);

        // Fill and overflow on lane2
        begin
            logic [7:0] fillData [5];
            fillData = '{8'hDD, 8'h99, 8'h77, 8'h88, 8'hCC};
            for (int k = 0; k < 5; k++) begin
                rv[2] = 1'b1; rIn[2] = 8'h10 + 8'(k); vIn[2] = 1'b1; dIn[2] = fillData[k]; tick();
                if (k == 3) begin
                    chk("lit_full_after4", 2, {7'd0, oFull[2]}, 8'h01);
                    chk("lit_no_ovf_yet", 2, {7'd0, oOvf[2]}, 8'h00);
                end
            end
            chk("lit_ovf_set", 2, {7'd0, oOvf[2]}, 8'h01);
            idleAll();
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("lit_drain", 2, oData[2], fillData[k]);
            end
            tick();
            chk("lit_drain_done", 2, {7'd0, oValid[2]}, 8'h00);
            chk("lit_ovf_sticky", 2, {7'd0, oOvf[2]}, 8'h01);
        end

        // Simultaneous push/pop at full on lane3
        begin
            logic [7:0] seq [5];
            seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h77};
            for (int k = 0; k < 4; k++) begin
                rv[3] = 1'b1; rIn[3] = 8'h50; vIn[3] = 1'b1; dIn[3] = seq[k]; tick();
            end
            rv[3] = 1'b0; rIn[3] = 'x; dIn[3] = 8'h77; tick();
            chk("lit_pp_head", 3, oData[3], 8'h11);
            chk("lit_pp_full", 3, {7'd0, oFull[3]}, 8'h01);
            chk("lit_pp_ovf", 3, {7'd0, oOvf[3]}, 8'h00);
            idleAll();
            for (int k = 1; k < 5; k++) begin
                tick();
                chk("lit_pp_drain", 3, oData[3], seq[k]);
            end
        end

        // Asynchronous reset mid-stream with three words queued on lane0
        for (int k = 0; k < 3; k++) begin
            rv[0] = 1'b1; rIn[0] = 8'h60; vIn[0] = 1'b1; dIn[0] = 8'h30 + 8'(k); tick();
        end
        rst = 1'b1;
        #1;
        chk("lit_async_data", 0, oData[0], 8'h00);
        chk("lit_async_valid", 0, {7'd0, oValid[0]}, 8'h00);
        chk("lit_async_ovf", 2, {7'd0, oOvf[2]}, 8'h00);
        idleAll();
        tick();
        rst = 1'b0;
        tick();
        chk("lit_post_reset_valid", 0, {7'd0, oValid[0]}, 8'h00);
        chk("lit_post_reset_full", 0, {7'd0, oFull[0]}, 8'h00);

        // Randomized traffic; invalid data is driven as garbage
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                rv[i]  = ($urandom_range(0, 99) < 55);
                vIn[i] = ($urandom_range(0, 99) < 60);
                rIn[i] = 8'($urandom);
                dIn[i] = 8'($urandom);
            end
            if (c == 1500) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
            tick();
        end
        idleAll();
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
